// File: rtl/tft_pkg.sv
// tft_pkg: shared command bytes and FSM encodings for the sprite blitter.
package tft_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Window setup is CASET + 4 address bytes, PASET + 4 address bytes, RAMWR.
    localparam int WIN_BYTES = 11;

    typedef enum logic [1:0] {
        IDLE,
        WIN,
        PIX,
        FIN
    } state_e;

    typedef enum logic {
        ERASE,
        SPRITE
    } pass_e;

endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: combinational (frame,row,col) -> pixel bit lookup.
// The bitmap is flattened MSB first: frame 0 row 0 col 0 is the top bit.
module sprite_rom #(
    parameter int SIZE       = 22,
    parameter int NUM_FRAMES = 3,
    parameter int FRAME_W    = 2,
    parameter int CNT_W      = 7
) (
    input  logic [FRAME_W-1:0] frame,
    input  logic [CNT_W-1:0]   row,
    input  logic [CNT_W-1:0]   col,
    output logic               pix
);

    localparam int TOTAL = NUM_FRAMES * SIZE * SIZE;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    // Frame art: 0 = hollow box with diagonal, 1 = checkerboard,
    // 2 = lower triangle below the diagonal (row 0 empty); repeats beyond 3.
    function automatic logic pattern(input int f, input int r, input int c);
        case (f % 3)
            0:       return (r == 0) || (r == SIZE - 1) || (c == 0) || (c == SIZE - 1) || (r == c);
            1:       return ((r + c) % 2) == 0;
            default: return (r != 0) && (c < r);
        endcase
    endfunction

    function automatic logic [TOTAL-1:0] build_bitmap();
        logic [TOTAL-1:0] bm;
        bm = '0;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    bm[TOTAL - 1 - ((f * SIZE + r) * SIZE + c)] = pattern(f, r, c);
                end
            end
        end
        return bm;
    endfunction

    localparam logic [TOTAL-1:0] BITMAP = build_bitmap();

    logic [IDX_W-1:0] idx;

    // Out-of-range frame/row/col reads as background.
    always_comb begin
        idx = IDX_W'(TOTAL - 1 - ((int'(frame) * SIZE + int'(row)) * SIZE + int'(col)));
        pix = 1'b0;
        if ((int'(frame) < NUM_FRAMES) && (int'(row) < SIZE) && (int'(col) < SIZE)) begin
            pix = BITMAP[idx];
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: erases the uncovered part of the old sprite position, then
// streams the new animated sprite through the tft byte driver handshake.
// Handshake: a byte is issued only when enable && !tft_busy && !tft_transmit;
// tft_transmit is high for exactly one cycle per byte, tft_dc/tft_data are
// valid in that cycle, and done rises together with the job's final strobe.
module sprite_blitter
    import tft_pkg::*;
#(
    parameter int          SIZE       = 22,
    parameter int          COORD_W    = 9,
    parameter int          BPP_BYTES  = 2,
    parameter int          NUM_FRAMES = 3,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter int          INIT_X     = 5,
    parameter int          INIT_Y     = 5,
    localparam int         FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [FRAME_W-1:0] frame,
    input  logic               draw,
    output logic               ready,
    output logic               done,
    input  logic               tft_busy,
    output logic               tft_transmit,
    output logic               tft_dc,
    output logic [7:0]         tft_data
);

    localparam int                 CNT_W     = 7;
    localparam logic [COORD_W-1:0] SZ        = COORD_W'(SIZE);
    localparam logic [COORD_W-1:0] SZ_M1     = COORD_W'(SIZE - 1);
    localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
    localparam logic [1:0]         LAST_BYTE = 2'(BPP_BYTES - 1);
    localparam logic [3:0]         LAST_WIN  = 4'(WIN_BYTES - 1);

    state_e             state_q, state_d;
    pass_e              pass_q, pass_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [COORD_W-1:0] new_x_q, new_x_d, new_y_q, new_y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               valid_old_q, valid_old_d;
    logic [3:0]         win_idx_q, win_idx_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   col_q, col_d, row_q, row_d;
    logic               transmit_q, transmit_d;
    logic               dc_q, dc_d;
    logic [7:0]         data_q, data_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic [COORD_W-1:0] ex_min, ex_max, ey_min, ey_max;
    logic [COORD_W-1:0] wx_min, wx_max, wy_min, wy_max;
    logic [7:0]         win_byte;
    logic               win_dc;
    logic               rom_bit;
    logic [23:0]        pix_color;
    logic [7:0]         pix_byte;
    logic               can_issue, col_last, row_last;

    function automatic logic [7:0] hi_byte(input logic [COORD_W-1:0] v);
        logic [15:0] w;
        w = 16'(v);
        return w[15:8];
    endfunction

    function automatic logic [7:0] lo_byte(input logic [COORD_W-1:0] v);
        logic [15:0] w;
        w = 16'(v);
        return w[7:0];
    endfunction

    sprite_rom #(
        .SIZE       (SIZE),
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_W    (FRAME_W),
        .CNT_W      (CNT_W)
    ) u_rom (
        .frame (frame_q),
        .row   (row_q),
        .col   (col_q),
        .pix   (rom_bit)
    );

    // Erase rectangle: a strip when the move is purely horizontal or vertical
    // with overlap, otherwise the whole old rectangle.
    always_comb begin
        ex_min = pos_x_q;
        ex_max = pos_x_q + SZ_M1;
        ey_min = pos_y_q;
        ey_max = pos_y_q + SZ_M1;
        if (new_y_q == pos_y_q && pos_x_q < new_x_q && (new_x_q - pos_x_q) < SZ) begin
            ex_max = new_x_q - ONE;
        end else if (new_y_q == pos_y_q && new_x_q < pos_x_q && (pos_x_q - new_x_q) < SZ) begin
            ex_min = new_x_q + SZ;
        end else if (new_x_q == pos_x_q && pos_y_q < new_y_q && (new_y_q - pos_y_q) < SZ) begin
            ey_max = new_y_q - ONE;
        end else if (new_x_q == pos_x_q && new_y_q < pos_y_q && (pos_y_q - new_y_q) < SZ) begin
            ey_min = new_y_q + SZ;
        end
    end

    // Active window for the current pass, window byte and pixel byte muxes.
    always_comb begin
        wx_min = (pass_q == ERASE) ? ex_min : new_x_q;
        wx_max = (pass_q == ERASE) ? ex_max : new_x_q + SZ_M1;
        wy_min = (pass_q == ERASE) ? ey_min : new_y_q;
        wy_max = (pass_q == ERASE) ? ey_max : new_y_q + SZ_M1;
        win_dc = 1'b1;
        case (win_idx_q)
            4'd0:    begin win_byte = CMD_CASET; win_dc = 1'b0; end
            4'd1:    win_byte = hi_byte(wx_min);
            4'd2:    win_byte = lo_byte(wx_min);
            4'd3:    win_byte = hi_byte(wx_max);
            4'd4:    win_byte = lo_byte(wx_max);
            4'd5:    begin win_byte = CMD_PASET; win_dc = 1'b0; end
            4'd6:    win_byte = hi_byte(wy_min);
            4'd7:    win_byte = lo_byte(wy_min);
            4'd8:    win_byte = hi_byte(wy_max);
            4'd9:    win_byte = lo_byte(wy_max);
            default: begin win_byte = CMD_RAMWR; win_dc = 1'b0; end
        endcase
        pix_color = (pass_q == SPRITE && rom_bit) ? FG_COLOR : BG_COLOR;
        pix_byte  = 8'(pix_color >> (8 * (BPP_BYTES - 1 - int'(bcnt_q))));
        col_last  = (col_q == CNT_W'(wx_max - wx_min));
        row_last  = (row_q == CNT_W'(wy_max - wy_min));
        can_issue = !tft_busy && !transmit_q;
    end

    // Next-state logic: everything holds while enable is low; strobe/done self-clear.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        frame_d     = frame_q;
        valid_old_d = valid_old_q;
        win_idx_d   = win_idx_q;
        bcnt_d      = bcnt_q;
        col_d       = col_q;
        row_d       = row_q;
        dc_d        = dc_q;
        data_d      = data_q;
        ready_d     = ready_q;
        transmit_d  = 1'b0;
        done_d      = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (draw && ready_q) begin
                        new_x_d   = x;
                        new_y_d   = y;
                        frame_d   = frame;
                        ready_d   = 1'b0;
                        win_idx_d = '0;
                        pass_d    = (valid_old_q && (x != pos_x_q || y != pos_y_q)) ? ERASE : SPRITE;
                        state_d   = WIN;
                    end
                end
                WIN: begin
                    if (can_issue) begin
                        transmit_d = 1'b1;
                        dc_d       = win_dc;
                        data_d     = win_byte;
                        if (win_idx_q == LAST_WIN) begin
                            bcnt_d  = '0;
                            col_d   = '0;
                            row_d   = '0;
                            state_d = PIX;
                        end else begin
                            win_idx_d = win_idx_q + 4'd1;
                        end
                    end
                end
                PIX: begin
                    if (can_issue) begin
                        transmit_d = 1'b1;
                        dc_d       = 1'b1;
                        data_d     = pix_byte;
                        if (bcnt_q != LAST_BYTE) begin
                            bcnt_d = bcnt_q + 2'd1;
                        end else begin
                            bcnt_d = '0;
                            if (!col_last) begin
                                col_d = col_q + 1'b1;
                            end else begin
                                col_d = '0;
                                if (!row_last) begin
                                    row_d = row_q + 1'b1;
                                end else if (pass_q == ERASE) begin
                                    pass_d    = SPRITE;
                                    win_idx_d = '0;
                                    state_d   = WIN;
                                end else begin
                                    done_d  = 1'b1;
                                    state_d = FIN;
                                end
                            end
                        end
                    end
                end
                FIN: begin
                    pos_x_d     = new_x_q;
                    pos_y_d     = new_y_q;
                    valid_old_d = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; reset aborts any job and forgets the old position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pass_q      <= SPRITE;
            pos_x_q     <= COORD_W'(INIT_X);
            pos_y_q     <= COORD_W'(INIT_Y);
            new_x_q     <= COORD_W'(INIT_X);
            new_y_q     <= COORD_W'(INIT_Y);
            frame_q     <= '0;
            valid_old_q <= 1'b0;
            win_idx_q   <= '0;
            bcnt_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            transmit_q  <= 1'b0;
            dc_q        <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            frame_q     <= frame_d;
            valid_old_q <= valid_old_d;
            win_idx_q   <= win_idx_d;
            bcnt_q      <= bcnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            transmit_q  <= transmit_d;
            dc_q        <= dc_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign tft_transmit = transmit_q;
    assign tft_dc       = dc_q;
    assign tft_data     = data_q;
    assign ready        = ready_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed and randomized jobs checked against a
// pixel-set reference model of the erase/draw byte stream.
module tb_sprite_blitter;

    localparam int          SIZE = 22;
    localparam int          CW   = 9;
    localparam int          BPP  = 2;
    localparam int          NF   = 3;
    localparam int          FW   = 2;
    localparam logic [23:0] FG   = 24'hFFFFFF;
    localparam logic [23:0] BG   = 24'h000000;
    localparam int          WINB = 11;
    localparam int          SPRB = SIZE * SIZE * BPP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          draw = 1'b0;
    logic [CW-1:0] x = '0;
    logic [CW-1:0] y = '0;
    logic [FW-1:0] frame = '0;
    logic          tft_busy;
    logic          ready, done, tft_transmit, tft_dc;
    logic [7:0]    tft_data;

    int checks = 0;
    int failures = 0;

    // captured and expected {dc, data} streams
    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];
    int done_cnt = 0, done_len = 0, done_lone = 0, dbl_strobe = 0;
    logic prev_tx = 1'b0;

    bit busy_rand = 1'b0, busy_hold = 1'b0;
    int base = 0, dbase = 0;
    int pend_x = 0, pend_y = 0;
    int m_px = 5, m_py = 5;
    bit m_valid = 1'b0;

    sprite_blitter #(
        .SIZE(SIZE), .COORD_W(CW), .BPP_BYTES(BPP), .NUM_FRAMES(NF),
        .FG_COLOR(FG), .BG_COLOR(BG), .INIT_X(5), .INIT_Y(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .x(x), .y(y), .frame(frame),
        .draw(draw), .ready(ready), .done(done), .tft_busy(tft_busy),
        .tft_transmit(tft_transmit), .tft_dc(tft_dc), .tft_data(tft_data)
    );

    // ---------------- clock / busy driver / monitor ----------------
    always #5 clk = ~clk;

    initial begin
        tft_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_hold) tft_busy = 1'b1;
            else if (busy_rand) tft_busy = ($urandom_range(0, 3) == 0);
            else tft_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_tx = 1'b0;
        end else begin
            if (tft_transmit) cap_q.push_back({tft_dc, tft_data});
            if (done) begin
                done_cnt++;
                done_len = cap_q.size();
                if (!tft_transmit) done_lone++;
            end
            if (tft_transmit && prev_tx) dbl_strobe++;
            prev_tx = tft_transmit;
        end
    end

    // ---------------- reference model ----------------
    function automatic bit ref_bit(int f, int r, int c);
        if (f == 0) return (r == 0 || r == SIZE - 1 || c == 0 || c == SIZE - 1 || r == c);
        if (f == 1) return ((r + c) % 2) == 0;
        return c < r;
    endfunction

    task automatic push_byte(bit dc, logic [7:0] b);
        exp_q.push_back({dc, b});
    endtask

    task automatic push_rect(int x0, int x1, int y0, int y1, int f, bit erase);
        logic [23:0] color;
        push_byte(0, 8'h2A);
        push_byte(1, 8'(x0 >> 8)); push_byte(1, 8'(x0));
        push_byte(1, 8'(x1 >> 8)); push_byte(1, 8'(x1));
        push_byte(0, 8'h2B);
        push_byte(1, 8'(y0 >> 8)); push_byte(1, 8'(y0));
        push_byte(1, 8'(y1 >> 8)); push_byte(1, 8'(y1));
        push_byte(0, 8'h2C);
        for (int r = 0; r <= y1 - y0; r++) begin
            for (int c = 0; c <= x1 - x0; c++) begin
                color = (!erase && ref_bit(f, r, c)) ? FG : BG;
                for (int b = BPP - 1; b >= 0; b--) push_byte(1, color[b*8 +: 8]);
            end
        end
    endtask

    // Erase = old pixels not covered by the new sprite; if that set is not a
    // single rectangle the whole old rectangle is cleared.
    task automatic plan_job(int nx, int ny, int nf);
        int x0, x1, y0, y1, cnt;
        exp_q.delete();
        if (m_valid) begin
            cnt = 0; x0 = 1 << 20; x1 = -1; y0 = 1 << 20; y1 = -1;
            for (int r = m_py; r < m_py + SIZE; r++) begin
                for (int c = m_px; c < m_px + SIZE; c++) begin
                    if (!(c >= nx && c < nx + SIZE && r >= ny && r < ny + SIZE)) begin
                        cnt++;
                        if (c < x0) x0 = c;
                        if (c > x1) x1 = c;
                        if (r < y0) y0 = r;
                        if (r > y1) y1 = r;
                    end
                end
            end
            if (cnt > 0) begin
                if (cnt != (x1 - x0 + 1) * (y1 - y0 + 1)) begin
                    x0 = m_px; x1 = m_px + SIZE - 1; y0 = m_py; y1 = m_py + SIZE - 1;
                end
                push_rect(x0, x1, y0, y1, 0, 1'b1);
            end
        end
        push_rect(nx, nx + SIZE - 1, ny, ny + SIZE - 1, nf, 1'b0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_job(int nx, int ny, int nf);
        int t;
        plan_job(nx, ny, nf);
        pend_x = nx; pend_y = ny;
        t = 0;
        while (ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait: ready=%b required 1", ready);
        end
        @(negedge clk);
        base = cap_q.size();
        dbase = done_cnt;
        x = CW'(nx); y = CW'(ny); frame = FW'(nf);
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int t;
        t = 0;
        while (done_cnt == dbase && t < 20000) begin @(negedge clk); t++; end
        ok = (done_cnt > dbase);
        repeat (4) @(negedge clk);
        if (ok) begin m_px = pend_x; m_py = pend_y; m_valid = 1'b1; end
    endtask

    task automatic wait_bytes(int n, output bit ok);
        int t;
        t = 0;
        while (cap_q.size() - base <= n && t < 10000) begin @(negedge clk); t++; end
        ok = (cap_q.size() - base > n);
    endtask

    function automatic int stream_errors();
        int e;
        e = 0;
        if (cap_q.size() - base != exp_q.size()) e++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= cap_q.size()) e++;
            else if (cap_q[base + i] !== exp_q[i]) e++;
        end
        return e;
    endfunction

    function automatic logic [8:0] cap_at(int i);
        if (base + i >= cap_q.size()) return 9'h1FF;
        return cap_q[base + i];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b exp 1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b exp 0", done); end
        checks++; if (tft_transmit !== 1'b0) begin failures++; $display("FAIL rst_tx: got %b exp 0", tft_transmit); end
        checks++; if (tft_dc !== 1'b0) begin failures++; $display("FAIL rst_dc: got %b exp 0", tft_dc); end
        checks++; if (tft_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h exp 00", tft_data); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tft_transmit !== 1'b0 || ready !== 1'b1) begin
            failures++; $display("FAIL post_rst_idle: tx=%b ready=%b exp 0/1", tft_transmit, ready);
        end
    endtask

    task automatic test_first_draw();
        bit ok;
        int e;
        logic [7:0] hdr [WINB];
        logic [8:0] v;
        hdr = '{8'h2A, 8'h00, 8'h0A, 8'h00, 8'h1F, 8'h2B, 8'h00, 8'h14, 8'h00, 8'h29, 8'h2C};
        start_job(10, 20, 0);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL first_done_timeout: done=%0d exp 1", done_cnt - dbase); end
        e = 0;
        for (int i = 0; i < WINB; i++) begin
            v = cap_at(i);
            if (v[7:0] !== hdr[i]) e++;
        end
        checks++; if (e !== 0) begin failures++; $display("FAIL first_header: %0d bad bytes exp 0", e); end
        checks++; if (cap_q.size() - base !== WINB + SPRB) begin
            failures++; $display("FAIL first_len: got %0d exp %0d", cap_q.size() - base, WINB + SPRB);
        end
        e = stream_errors();
        checks++; if (e !== 0) begin failures++; $display("FAIL first_stream: %0d errors exp 0", e); end
        checks++; if (done_cnt - dbase !== 1) begin failures++; $display("FAIL first_done_cnt: got %0d exp 1", done_cnt - dbase); end
        checks++; if (done_len - base !== exp_q.size()) begin
            failures++; $display("FAIL first_done_pos: got %0d exp %0d", done_len - base, exp_q.size());
        end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL first_ready: got %b exp 1", ready); end
    endtask

    task automatic test_strip_move();
        bit ok;
        int e;
        logic [8:0] v1, v2, v3, v4;
        start_job(13, 20, 0);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL strip_done_timeout: exp done"); end
        checks++; if (cap_q.size() - base !== 11 + 132 + 11 + 968) begin
            failures++; $display("FAIL strip_len: got %0d exp %0d", cap_q.size() - base, 11 + 132 + 11 + 968);
        end
        v1 = cap_at(1); v2 = cap_at(2); v3 = cap_at(3); v4 = cap_at(4);
        checks++; if ({v1[7:0], v2[7:0], v3[7:0], v4[7:0]} !== 32'h000A000C) begin
            failures++; $display("FAIL strip_xwin: got %h%h%h%h exp 000A000C", v1[7:0], v2[7:0], v3[7:0], v4[7:0]);
        end
        e = stream_errors();
        checks++; if (e !== 0) begin failures++; $display("FAIL strip_stream: %0d errors exp 0", e); end
    endtask

    task automatic test_same_pos_frame2();
        bit ok;
        int e;
        logic [8:0] v;
        start_job(13, 20, 2);
        wait_done(ok);
        checks++; if (cap_q.size() - base !== WINB + SPRB || ok !== 1'b1) begin
            failures++; $display("FAIL same_len: got %0d exp %0d", cap_q.size() - base, WINB + SPRB);
        end
        e = 0;
        for (int i = 0; i < SIZE * BPP; i++) begin
            v = cap_at(WINB + i);
            if (v !== 9'h100) e++;
        end
        checks++; if (e !== 0) begin failures++; $display("FAIL same_row0_bg: %0d non-BG bytes exp 0", e); end
        e = stream_errors();
        checks++; if (e !== 0) begin failures++; $display("FAIL same_stream: %0d errors exp 0", e); end
    endtask

    task automatic test_far_move();
        bit ok;
        int e;
        logic [8:0] v1, v2, v3, v4;
        start_job(300, 50, 0);
        wait_done(ok);
        checks++; if (cap_q.size() - base !== 2 * (WINB + SPRB) || ok !== 1'b1) begin
            failures++; $display("FAIL far_len: got %0d exp %0d", cap_q.size() - base, 2 * (WINB + SPRB));
        end
        v1 = cap_at(WINB + SPRB + 1); v2 = cap_at(WINB + SPRB + 2);
        v3 = cap_at(WINB + SPRB + 3); v4 = cap_at(WINB + SPRB + 4);
        checks++; if ({v1[7:0], v2[7:0], v3[7:0], v4[7:0]} !== 32'h012C0141) begin
            failures++; $display("FAIL far_xwin: got %h%h%h%h exp 012C0141", v1[7:0], v2[7:0], v3[7:0], v4[7:0]);
        end
        e = stream_errors();
        checks++; if (e !== 0) begin failures++; $display("FAIL far_stream: %0d errors exp 0", e); end
    endtask

    task automatic test_busy_freeze();
        bit ok;
        int e, s0, s1;
        start_job(300, 55, 1);
        wait_bytes(60, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL busy_reach_pix: bytes=%0d exp >60", cap_q.size() - base); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b exp 0", ready); end
        x = '0; y = '0; draw = 1'b1;
        @(negedge clk); draw = 1'b0;
        busy_hold = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        s0 = cap_q.size();
        repeat (50) @(negedge clk);
        s1 = cap_q.size();
        busy_hold = 1'b0;
        checks++; if (s1 - s0 !== 0) begin failures++; $display("FAIL busy_hold_strobes: got %0d exp 0", s1 - s0); end
        @(negedge clk); enable = 1'b0;
        @(posedge clk); #1;
        s0 = cap_q.size();
        repeat (20) @(negedge clk);
        s1 = cap_q.size();
        enable = 1'b1;
        checks++; if (s1 - s0 !== 0) begin failures++; $display("FAIL freeze_strobes: got %0d exp 0", s1 - s0); end
        wait_done(ok);
        e = stream_errors();
        checks++; if (e !== 0 || ok !== 1'b1) begin failures++; $display("FAIL busy_stream: %0d errors exp 0", e); end
        s0 = cap_q.size();
        repeat (30) @(negedge clk);
        checks++; if (cap_q.size() - s0 !== 0 || done_cnt - dbase !== 1) begin
            failures++; $display("FAIL ignored_draw: extra=%0d dones=%0d exp 0/1", cap_q.size() - s0, done_cnt - dbase);
        end
    endtask

    task automatic test_reset_mid_pix();
        bit ok;
        int e;
        start_job(100, 100, 1);
        wait_bytes(40, ok);
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++; if (tft_transmit !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL reset_abort: tx=%b ready=%b done=%b exp 0/1/0", tft_transmit, ready, done);
        end
        m_valid = 1'b0; m_px = 5; m_py = 5;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_job(40, 40, 0);
        wait_done(ok);
        checks++; if (cap_q.size() - base !== WINB + SPRB || ok !== 1'b1) begin
            failures++; $display("FAIL post_reset_len: got %0d exp %0d", cap_q.size() - base, WINB + SPRB);
        end
        e = stream_errors();
        checks++; if (e !== 0) begin failures++; $display("FAIL post_reset_stream: %0d errors exp 0", e); end
    endtask

    task automatic test_random();
        bit ok;
        int e, mode, nx, ny, nf, d;
        busy_rand = 1'b1;
        for (int j = 0; j < 6; j++) begin
            mode = $urandom_range(0, 3);
            nf = $urandom_range(0, NF - 1);
            d = $urandom_range(1, SIZE + 3);
            if ($urandom_range(0, 1) == 1) d = -d;
            nx = m_px; ny = m_py;
            if (mode == 1) nx = m_px + d;
            else if (mode == 2) ny = m_py + d;
            else if (mode == 3) begin nx = $urandom_range(0, 490); ny = $urandom_range(0, 490); end
            if (nx < 0 || nx > 490) nx = $urandom_range(0, 490);
            if (ny < 0 || ny > 490) ny = $urandom_range(0, 490);
            start_job(nx, ny, nf);
            wait_done(ok);
            e = stream_errors();
            checks++; if (e !== 0 || ok !== 1'b1) begin
                failures++; $display("FAIL rand_stream[%0d] (%0d,%0d,f%0d): %0d errors exp 0", j, nx, ny, nf, e);
            end
            checks++; if (done_cnt - dbase !== 1) begin
                failures++; $display("FAIL rand_done[%0d]: got %0d exp 1", j, done_cnt - dbase);
            end
        end
        busy_rand = 1'b0;
    endtask

    task automatic test_protocol();
        checks++; if (dbl_strobe !== 0) begin failures++; $display("FAIL strobe_width: got %0d back-to-back exp 0", dbl_strobe); end
        checks++; if (done_lone !== 0) begin failures++; $display("FAIL done_align: got %0d lone pulses exp 0", done_lone); end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_strip_move();
        test_same_pos_frame2();
        test_far_move();
        test_busy_freeze();
        test_reset_mid_pix();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Parametrised successor to the single-size, solid-colour player drawer. Moves one animated SIZE x SIZE sprite on the TFT: erases only the uncovered strip (or the whole old rectangle), then streams the new sprite through the byte-level tft driver handshake. Adds configurable colour depth, foreground/background colours, multiple animation frames, exact strip geometry, and draw-request/done signalling. Sits between game logic (position/frame source) and the shared tft byte transmitter.

Parameters:
SIZE, 22, sprite edge in pixels (2..64)
COORD_W, 9, coordinate width; address bytes are {zero pad, coord[COORD_W-1:8]} and coord[7:0]; COORD_W <= 16
BPP_BYTES, 2, bytes per pixel (1..3), MSB byte first
NUM_FRAMES, 3, animation frames in the sprite ROM
FG_COLOR, 24'hFFFFFF, pixel value for set bits; low BPP_BYTES*8 bits used
BG_COLOR, 24'h000000, pixel value for clear bits and erase fill
INIT_X, 5, initial position after reset
INIT_Y, 5, initial position after reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  clock enable; when 0 all state holds, tft_transmit forced 0
x  in  COORD_W  requested sprite left column
y  in  COORD_W  requested sprite top row
frame  in  clog2(NUM_FRAMES)  animation frame index
draw  in  1  request pulse; sampled only when ready=1
ready  out  1  idle, may accept draw
done  out  1  one-cycle pulse when last byte of a job is issued
tft_busy  in  1  driver busy
tft_transmit  out  1  one-cycle byte strobe
tft_dc  out  1  0 = command, 1 = data
tft_data  out  8  byte to send

Behaviour:
- Reset (async): state IDLE, ready=1, done=0, tft_transmit=0, tft_dc=0, tft_data=0, pos=(INIT_X,INIT_Y), valid_old=0.
- Byte issue: allowed only when enable && !tft_busy && !tft_transmit; tft_transmit high exactly one cycle per byte; cycle after any strobe it returns to 0.
- IDLE: draw && ready latches x,y,frame, ready<=0 next cycle. Erase region selection (old=(xo,yo), new=(xn,yn)):
  - !valid_old or same position: no erase.
  - yn==yo, xo<xn, xn-xo<SIZE: columns xo..xn-1, rows yo..yo+SIZE-1.
  - yn==yo, xn<xo, xo-xn<SIZE: columns xn+SIZE..xo+SIZE-1.
  - xn==xo: symmetric vertical strips.
  - otherwise: full old rectangle.
- WIN state: 11 bytes: 2A(cmd), xmin hi, xmin lo, xmax hi, xmax lo, 2B(cmd), ymin hi/lo, ymax hi/lo, 2C(cmd).
- PIX state: w*h pixels row-major, top-left first, BPP_BYTES bytes each, MSB byte first, dc=1. Erase pass: all BG_COLOR. Sprite pass: bit(frame,r,c) ? FG_COLOR : BG_COLOR.
- Sequence: [erase WIN+PIX] -> sprite WIN+PIX -> done pulse on same cycle as final strobe -> IDLE, ready=1 next cycle, pos<=new, valid_old<=1.
- Counters: byte-in-pixel 0..BPP_BYTES-1, col 0..w-1, row 0..h-1; no overflow for SIZE<=64.
- Coordinates unclipped; caller guarantees x+SIZE-1, y+SIZE-1 < 2^COORD_W. Arithmetic in COORD_W bits.
- draw while !ready: ignored, no queueing.
- enable=0 mid-job: freeze; resumes at the same byte.
- rst_n low mid-job: abort immediately, outputs to reset values; next draw performs no erase.

Decomposition:
- Package tft_pkg: command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C; state enum {IDLE, WIN, PIX, FIN}; pass enum {ERASE, SPRITE}.
- Sub-module sprite_rom: combinational lookup (frame,row,col)->bit; row 0 = MSB row of each frame's flattened bitmap, col 0 = MSB of that row.

Test Plan:
- Reset, draw (10,20) frame0 -> no erase; bytes 2A,00,0A,00,1F,2B,00,14,00,29,2C then 968 data bytes; one done pulse; ready=1.
- Then draw (13,20) -> erase window x 10..12, y 20..41, 132 bytes of 00; then sprite window x 13..34; total 11+132+11+968 strobes.
- Then draw (13,20) frame2 -> no erase; 979 strobes; data bytes match frame2 bitmap (row 0 all BG).
- Then draw (300,50) -> full erase of 13..34 x 20..41 (968 bytes 00); sprite window bytes 01,2C,01,41 for x.
- draw pulsed while busy -> ignored; tft_busy held high 50 cycles mid-PIX -> no strobes, no lost/duplicated bytes (count check).
- rst_n low during PIX -> tft_transmit=0, ready=1 same cycle; next draw (40,40) -> no erase pass.
